c_skip_add_pipe: RTL and testbench

- Parametrised, pipelined carry-skip adder/subtractor; successor to the fixed 8-bit two-block carry-skip adder.
- Operand width, skip-block size and blocks-per-pipeline-stage are generic.
- Adds a subtract mode, a signed-overflow flag and a valid/ready stream interface with backpressure.
- Sits in datapaths that need a timed, throttled wide add, e.g. accumulators and address generators.

---
 rtl/c_skip_add_pipe_pkg.sv | 25 ++
 rtl/c_skip_add_pipe_if.sv | 35 +++
 rtl/c_skip_add_pipe_blk.sv | 42 ++++
 rtl/c_skip_add_pipe.sv | 145 ++++++++++++++
 tb/tb_c_skip_add_pipe.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/c_skip_add_pipe_pkg.sv
// Shared constants and elaboration helpers for the pipelined carry-skip adder.
package c_skip_add_pipe_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_BLK   = 4;
    localparam int DEF_BPS   = 2;

    // Number of register stages: one per group of BPS skip blocks.
    function automatic int nstage(input int width, input int blk, input int bps);
        if ((blk <= 0) || (bps <= 0)) begin
            return 0;
        end
        return width / (blk * bps);
    endfunction

    // The operand must split into a whole number of stages, each holding
    // a whole number of skip blocks.
    function automatic bit geometry_ok(input int width, input int blk, input int bps);
        if ((blk <= 0) || (bps <= 0) || (width <= 0)) begin
            return 1'b0;
        end
        return (width % (blk * bps)) == 0;
    endfunction

endpackage

// File: rtl/c_skip_add_pipe_if.sv
// Stream bundle for the adder: operand beat in, result beat out, each with
// its own valid/ready pair. Buses use [WIDTH:1] numbering, bit 1 = LSB.
interface c_skip_add_pipe_if
    import c_skip_add_pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    // Operand side
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH:1]   A;
    logic [WIDTH:1]   B;
    logic             cin;
    logic             sub;

    // Result side
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:1]   S;
    logic             cout;
    logic             ovf;

    // Producer/consumer environment around the adder
    modport master (
        output in_valid, A, B, cin, sub, out_ready,
        input  in_ready, out_valid, S, cout, ovf
    );

    // The adder itself
    modport slave (
        input  in_valid, A, B, cin, sub, out_ready,
        output in_ready, out_valid, S, cout, ovf
    );

endinterface

// File: rtl/c_skip_add_pipe_blk.sv
// One carry-skip block: BLK-bit ripple adder whose carry-out bypasses the
// ripple chain when every bit propagates.
module c_skip_blk
    import c_skip_add_pipe_pkg::*;
#(
    parameter int BLK = DEF_BLK
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           ci,
    output logic [BLK-1:0] s,
    output logic           co
);

    logic [BLK-1:0] p;
    logic [BLK-1:0] g;
    logic           rip_co;
    logic           skip;

    for (genvar gi = 0; gi < BLK; gi++) begin : g_pg
        assign p[gi] = a[gi] ^ b[gi];
        assign g[gi] = a[gi] & b[gi];
    end

    // Ripple the carry bit by bit; a local variable keeps the chain
    // free of self-referencing vector bits.
    always_comb begin
        logic carry;
        carry = ci;
        s     = '0;
        for (int i = 0; i < BLK; i++) begin
            s[i]  = p[i] ^ carry;
            carry = g[i] | (p[i] & carry);
        end
        rip_co = carry;
    end

    // When the whole block propagates, the incoming carry skips straight out.
    assign skip = &p;
    assign co   = skip ? ci : rip_co;

endmodule

// File: rtl/c_skip_add_pipe.sv
// Pipelined carry-skip adder/subtractor with a valid/ready stream interface.
// Each stage resolves BLK*BPS result bits and hands the carry, the still
// unresolved operand bits and the operand sign bits to the next stage.
// The whole pipe advances together; a stalled output freezes every stage.
module c_skip_add_pipe
    import c_skip_add_pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int BLK   = DEF_BLK,
    parameter int BPS   = DEF_BPS
) (
    input  logic              clk,
    input  logic              rst_n,
    c_skip_add_pipe_if.slave  bus
);

    localparam int SW     = BLK * BPS;
    localparam int NSTAGE = nstage(WIDTH, BLK, BPS);

    if (!geometry_ok(WIDTH, BLK, BPS)) begin : g_bad_geometry
        $fatal(1, "c_skip_add_pipe: WIDTH=%0d is not a multiple of BLK*BPS=%0d",
               WIDTH, BLK * BPS);
    end

    // Global advance enable: the pipe moves unless the last stage holds a
    // beat nobody is taking.
    logic             en;

    // Operands as seen by the adder core (zero-based, B already conditioned).
    logic [WIDTH-1:0] a_op;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

    assign a_op  = bus.A;
    assign b_eff = bus.B ^ {WIDTH{bus.sub}};
    assign c_eff = bus.cin ^ bus.sub;

    for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_st
        localparam int LO    = gi * SW;      // first bit resolved here
        localparam int IN_W  = WIDTH - LO;   // operand bits still unresolved on entry
        localparam int RES_W = LO + SW;      // result bits known after this stage

        logic [IN_W-1:0]  a_in;
        logic [IN_W-1:0]  b_in;
        logic             c_in;
        logic             am_in;
        logic             bm_in;
        logic             v_in;
        logic [SW-1:0]    slice_s;
        logic [RES_W-1:0] s_next;

        logic [RES_W-1:0] s_reg;
        logic             c_reg;
        logic             am_reg;
        logic             bm_reg;
        logic             v_reg;

        if (gi == 0) begin : g_head
            assign a_in   = a_op;
            assign b_in   = b_eff;
            assign c_in   = c_eff;
            assign am_in  = a_op[WIDTH-1];
            assign bm_in  = b_eff[WIDTH-1];
            assign v_in   = bus.in_valid;
            assign s_next = slice_s;
        end else begin : g_body
            assign a_in   = g_st[gi-1].g_fwd.a_fwd_reg;
            assign b_in   = g_st[gi-1].g_fwd.b_fwd_reg;
            assign c_in   = g_st[gi-1].c_reg;
            assign am_in  = g_st[gi-1].am_reg;
            assign bm_in  = g_st[gi-1].bm_reg;
            assign v_in   = g_st[gi-1].v_reg;
            assign s_next = {slice_s, g_st[gi-1].s_reg};
        end

        // BPS skip blocks chained within the stage; each block's carry-in
        // is its own net so the chain stays a plain feed-forward path.
        for (genvar gj = 0; gj < BPS; gj++) begin : g_blk
            logic ci;
            logic co;

            if (gj == 0) begin : g_first
                assign ci = c_in;
            end else begin : g_next
                assign ci = g_blk[gj-1].co;
            end

            c_skip_blk #(
                .BLK (BLK)
            ) u_blk (
                .a  (a_in[gj*BLK +: BLK]),
                .b  (b_in[gj*BLK +: BLK]),
                .ci (ci),
                .s  (slice_s[gj*BLK +: BLK]),
                .co (co)
            );
        end

        // Stage register: resolved sum, carry, sign bits and valid flag.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s_reg  <= '0;
                c_reg  <= 1'b0;
                am_reg <= 1'b0;
                bm_reg <= 1'b0;
                v_reg  <= 1'b0;
            end else if (en) begin
                s_reg  <= s_next;
                c_reg  <= g_blk[BPS-1].co;
                am_reg <= am_in;
                bm_reg <= bm_in;
                v_reg  <= v_in;
            end
        end

        // Upper operand bits travel on only while some stage still needs them.
        if (gi < NSTAGE - 1) begin : g_fwd
            localparam int FWD_W = IN_W - SW;

            logic [FWD_W-1:0] a_fwd_reg;
            logic [FWD_W-1:0] b_fwd_reg;

            // Forward the unresolved operand bits alongside the carry.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_fwd_reg <= '0;
                    b_fwd_reg <= '0;
                end else if (en) begin
                    a_fwd_reg <= a_in[IN_W-1:SW];
                    b_fwd_reg <= b_in[IN_W-1:SW];
                end
            end
        end
    end

    assign en            = !g_st[NSTAGE-1].v_reg || bus.out_ready;
    assign bus.in_ready  = en;
    assign bus.out_valid = g_st[NSTAGE-1].v_reg;
    assign bus.S         = g_st[NSTAGE-1].s_reg;
    assign bus.cout      = g_st[NSTAGE-1].c_reg;
    // Overflow: like-signed addends giving a result of the other sign.
    assign bus.ovf       = (g_st[NSTAGE-1].am_reg == g_st[NSTAGE-1].bm_reg) &&
                           (g_st[NSTAGE-1].s_reg[WIDTH-1] != g_st[NSTAGE-1].am_reg);

endmodule

// File: tb/tb_c_skip_add_pipe.sv
// Scoreboard bench for c_skip_add_pipe (WIDTH=16, BLK=4, BPS=2).
// Accepted beats push a model result; a monitor compares whenever a result
// is presented and pops when it is taken.
module tb_c_skip_add_pipe;

    localparam int W     = 16;
    localparam int N_RND = 10000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    c_skip_add_pipe_if #(.WIDTH(W)) bus ();

    c_skip_add_pipe #(
        .WIDTH (W),
        .BLK   (4),
        .BPS   (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] s;
        logic         cout;
        logic         ovf;
    } beat_t;

    beat_t exp_q[$];
    int    total   = 0;
    int    bad     = 0;
    int    acc_cnt = 0;
    int    out_cnt = 0;

    // Reference: plain integer arithmetic. Unsigned result for {cout,S},
    // true signed result for the overflow flag.
    function automatic beat_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic cin, input logic sub);
        beat_t  e;
        longint u;
        longint sa;
        longint sb;
        longint sg;
        e.a   = a;
        e.b   = b;
        e.cin = cin;
        e.sub = sub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sub) begin
            u  = longint'(a) - longint'(b) - longint'(cin) + 65536;
            sg = sa - sb - longint'(cin);
        end else begin
            u  = longint'(a) + longint'(b) + longint'(cin);
            sg = sa + sb + longint'(cin);
        end
        e.s    = u[W-1:0];
        e.cout = u[W];
        e.ovf  = (sg > 32767) || (sg < -32768);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: sampled on the falling edge, between driver updates.
    always @(negedge clk) begin : mon
        beat_t e;
        if (rst_n) begin
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(bus.A, bus.B, bus.cin, bus.sub));
                acc_cnt++;
            end
            if (bus.out_valid) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_out: got S=%h cout=%b ovf=%b with nothing pending",
                             bus.S, bus.cout, bus.ovf);
                end else begin
                    e = exp_q[0];
                    if ({bus.cout, bus.S, bus.ovf} !== {e.cout, e.s, e.ovf}) begin
                        bad++;
                        $display("FAIL result A=%h B=%h cin=%b sub=%b: got S=%h cout=%b ovf=%b expected S=%h cout=%b ovf=%b",
                                 e.a, e.b, e.cin, e.sub, bus.S, bus.cout, bus.ovf, e.s, e.cout, e.ovf);
                    end
                    if (bus.out_ready) begin
                        void'(exp_q.pop_front());
                        out_cnt++;
                        $display("beat %0d: A=%h B=%h cin=%b sub=%b -> S=%h cout=%b ovf=%b",
                                 out_cnt, e.a, e.b, e.cin, e.sub, bus.S, bus.cout, bus.ovf);
                    end
                end
            end
        end
    end

    // Present one beat and hold it until the adder takes it.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub);
        bit done;
        bit take;
        done = 1'b0;
        bus.in_valid = 1'b1;
        bus.A        = a;
        bus.B        = b;
        bus.cin      = cin;
        bus.sub      = sub;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            take = bus.in_ready;
            @(posedge clk);
            #1;
            done = take;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got in_ready stuck low expected acceptance");
        end
        bus.in_valid = 1'b0;
    endtask

    // Single beat into an idle pipe with out_ready high: checks latency and
    // the result against hand-computed constants.
    task automatic directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic sub,
                            input logic [W-1:0] s_req, input logic cout_req, input logic ovf_req);
        send(a, b, cin, sub);
        check({name, "_valid_early"}, 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        check({name, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({name, "_S"},     32'(bus.S),         32'(s_req));
        check({name, "_cout"},  32'(bus.cout),      32'(cout_req));
        check({name, "_ovf"},   32'(bus.ovf),       32'(ovf_req));
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 500 && exp_q.size() != 0; i++) begin
            @(posedge clk);
        end
        #1;
        check({name, "_drain_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin : watchdog
        #3ms;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int base_acc;
        int base_out;
        bit rnd_done;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_S",         32'(bus.S),         32'd0);
        check("rst_cout",      32'(bus.cout),      32'd0);
        check("rst_ovf",       32'(bus.ovf),       32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Directed arithmetic cases
        bus.out_ready = 1'b1;
        directed("add",      16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        directed("wrap",     16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        directed("pos_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        directed("sub",      16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        directed("sub_ovf",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        directed("propag",   16'h5555, 16'hAAAA, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        directed("sub_brw1", 16'h0010, 16'h0010, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0);
        wait_drain("directed");

        // Backpressure: pipe fills with two beats then refuses more
        bus.out_ready = 1'b0;
        base_acc = acc_cnt;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
                end
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                check("bp_accepted", 32'(acc_cnt - base_acc), 32'd2);
                check("bp_in_ready", 32'(bus.in_ready),       32'd0);
                check("bp_valid",    32'(bus.out_valid),      32'd1);
                bus.out_ready = 1'b1;
            end
        join
        wait_drain("bp");
        check("bp_total_accepted", 32'(acc_cnt - base_acc), 32'd4);

        // Reset with two beats in flight
        send(16'h0101, 16'h0202, 1'b0, 1'b0);
        send(16'h0303, 16'h0404, 1'b0, 1'b0);
        check("mid_valid_before", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid",    32'(bus.out_valid), 32'd0);
        check("mid_rst_S",        32'(bus.S),         32'd0);
        check("mid_rst_cout",     32'(bus.cout),      32'd0);
        check("mid_rst_in_ready", 32'(bus.in_ready),  32'd1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        base_out = out_cnt;
        directed("after_rst", 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);
        wait_drain("after_rst");
        check("after_rst_count", 32'(out_cnt - base_out), 32'd1);

        // Random traffic with random stalls on both sides
        base_out = out_cnt;
        rnd_done = 1'b0;
        fork
            begin
                for (int n = 0; n < N_RND; n++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    ra = W'($urandom);
                    rb = W'($urandom);
                    case ($urandom_range(0, 7))
                        0: rb = ~ra;
                        1: ra = '1;
                        2: rb = '0;
                        3: ra = {1'b0, {(W-1){1'b1}}};
                        default: ;
                    endcase
                    send(ra, rb, 1'($urandom), 1'($urandom));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
                bus.out_ready = 1'b1;
            end
        join
        wait_drain("rnd");
        check("rnd_count", 32'(out_cnt - base_out), 32'(N_RND));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
